// File: rtl/condicionador_botoes_pkg.sv
// Purpose: shared FSM state encoding and 50 MHz timing defaults for the button conditioner.
// Latency: none (constants and a helper function only).
// Backpressure: none; optional autorepeat is selected by CONDICIONADOR_AUTOREPEAT_EN.
package cond_botoes_pkg;

  // Per-channel debounce FSM states
  localparam logic [1:0] SOLTO          = 2'd0;
  localparam logic [1:0] CONFIRMA_PRESS = 2'd1;
  localparam logic [1:0] PRESSIONADO    = 2'd2;
  localparam logic [1:0] CONFIRMA_SOLTA = 2'd3;

  // Timing defaults at 50 MHz: 20 ms debounce, 500 ms first repeat, 200 ms repeat period
  localparam int DEBOUNCE_PADRAO       = 1000000;
  localparam int REPEAT_ATRASO_PADRAO  = 25000000;
  localparam int REPEAT_PERIODO_PADRAO = 10000000;

  // A channel reports "pressed" while held or while a release is still being confirmed
  function automatic logic estado_pressionado(input logic [1:0] estado);
    return (estado == PRESSIONADO) || (estado == CONFIRMA_SOLTA);
  endfunction

endpackage

// File: rtl/condicionador_botoes_if.sv
// Purpose: bundles raw buttons, control inputs and conditioned outputs of the button conditioner.
// Latency: none (wires only).
// Backpressure: none; pulses are fire-and-forget single-cycle strobes.
interface condicionador_botoes_if #(
  parameter int N_BOTOES     = 8,
  parameter int LARGURA_CONT = 8
);
  logic [N_BOTOES-1:0]     botoes_raw;
  logic                    habilita;
  logic                    limpa_contagem;
  logic [N_BOTOES-1:0]     pulsos;
  logic [N_BOTOES-1:0]     estavel;
  logic [LARGURA_CONT-1:0] contagem_jogadas;
  logic                    contagem_cheia;

  modport master (
    output botoes_raw, habilita, limpa_contagem,
    input  pulsos, estavel, contagem_jogadas, contagem_cheia
  );

  modport slave (
    input  botoes_raw, habilita, limpa_contagem,
    output pulsos, estavel, contagem_jogadas, contagem_cheia
  );
endinterface

// File: rtl/condicionador_botoes_debounce_canal.sv
// Purpose: one button channel: 2-flop sync, debounce FSM, press pulse (optional CONDICIONADOR_AUTOREPEAT_EN).
// Latency: pulse registered DEBOUNCE_CYCLES+3 edges after the edge that first samples a steady press.
// Backpressure: none; habilita only masks the pulse, the FSM always runs.
module debounce_canal
  import cond_botoes_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_PADRAO,
  parameter int ATIVO_BAIXO     = 1
`ifdef CONDICIONADOR_AUTOREPEAT_EN
  ,
  parameter int REPEAT_ATRASO   = REPEAT_ATRASO_PADRAO,
  parameter int REPEAT_PERIODO  = REPEAT_PERIODO_PADRAO
`endif
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  input  logic habilita,
  output logic pulso,
  output logic estavel
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_FIM = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic [1:0]    estado_q, estado_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pulso_q, pulso_d;
  logic          aceite;
  logic          s;

  // Inversion happens before the synchroniser so its reset value 0 means "released"
  assign sync1_d = (ATIVO_BAIXO != 0) ? ~raw : raw;
  assign sync2_d = sync1_q;
  assign s       = sync2_q;

  // Debounce FSM: a level change is accepted only after DEBOUNCE_CYCLES stable samples
  always_comb begin
    estado_d = estado_q;
    cnt_d    = cnt_q;
    aceite   = 1'b0;
    case (estado_q)
      SOLTO: begin
        if (s) begin
          estado_d = CONFIRMA_PRESS;
          cnt_d    = '0;
        end
      end
      CONFIRMA_PRESS: begin
        if (!s) begin
          estado_d = SOLTO;
          cnt_d    = '0;
        end else if (cnt_q == CNT_FIM) begin
          estado_d = PRESSIONADO;
          cnt_d    = '0;
          aceite   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PRESSIONADO: begin
        if (!s) begin
          estado_d = CONFIRMA_SOLTA;
          cnt_d    = '0;
        end
      end
      CONFIRMA_SOLTA: begin
        if (s) begin
          estado_d = PRESSIONADO;
          cnt_d    = '0;
        end else if (cnt_q == CNT_FIM) begin
          estado_d = SOLTO;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        estado_d = SOLTO;
        cnt_d    = '0;
      end
    endcase
  end

`ifdef CONDICIONADOR_AUTOREPEAT_EN
  localparam int RMAX = (REPEAT_ATRASO > REPEAT_PERIODO) ? REPEAT_ATRASO : REPEAT_PERIODO;
  localparam int RW   = (RMAX > 1) ? $clog2(RMAX) : 1;
  localparam logic [RW-1:0] ATRASO_FIM  = RW'(REPEAT_ATRASO - 1);
  localparam logic [RW-1:0] PERIODO_FIM = RW'(REPEAT_PERIODO - 1);

  logic [RW-1:0] rep_cnt_q, rep_cnt_d;
  logic          rep_fase_q, rep_fase_d;
  logic          repete;

  // Hold timer: first repeat after REPEAT_ATRASO, then every REPEAT_PERIODO while held
  always_comb begin
    rep_cnt_d  = rep_cnt_q;
    rep_fase_d = rep_fase_q;
    repete     = 1'b0;
    if (aceite) begin
      rep_cnt_d  = '0;
      rep_fase_d = 1'b0;
    end else if (estado_q == PRESSIONADO) begin
      if ((!rep_fase_q && rep_cnt_q == ATRASO_FIM) || (rep_fase_q && rep_cnt_q == PERIODO_FIM)) begin
        repete     = 1'b1;
        rep_cnt_d  = '0;
        rep_fase_d = 1'b1;
      end else begin
        rep_cnt_d = rep_cnt_q + 1'b1;
      end
    end
  end

  // Repeat timer state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rep_cnt_q  <= '0;
      rep_fase_q <= 1'b0;
    end else begin
      rep_cnt_q  <= rep_cnt_d;
      rep_fase_q <= rep_fase_d;
    end
  end

  assign pulso_d = (aceite | repete) & habilita;
`else
  // Enable is sampled on the acceptance cycle only, so re-enabling later never emits a late pulse
  assign pulso_d = aceite & habilita;
`endif

  // Synchroniser, FSM, counter and pulse register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      estado_q <= SOLTO;
      cnt_q    <= '0;
      pulso_q  <= 1'b0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      estado_q <= estado_d;
      cnt_q    <= cnt_d;
      pulso_q  <= pulso_d;
    end
  end

  assign pulso   = pulso_q;
  assign estavel = estado_pressionado(estado_q);

endmodule

// File: rtl/condicionador_botoes.sv
// Purpose: conditions N_BOTOES raw buttons into press pulses plus a saturating move counter (CONDICIONADOR_AUTOREPEAT_EN optional).
// Latency: pulses DEBOUNCE_CYCLES+3 edges after first sample of a steady press; counter one edge later.
// Backpressure: none; habilita=0 suppresses pulses and counting while debouncing continues.
module condicionador_botoes
  import cond_botoes_pkg::*;
#(
  parameter int N_BOTOES        = 8,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_PADRAO,
  parameter int ATIVO_BAIXO     = 1,
  parameter int LARGURA_CONT    = 8
`ifdef CONDICIONADOR_AUTOREPEAT_EN
  ,
  parameter int REPEAT_ATRASO   = REPEAT_ATRASO_PADRAO,
  parameter int REPEAT_PERIODO  = REPEAT_PERIODO_PADRAO
`endif
) (
  input logic                  clk,
  input logic                  rst,
  condicionador_botoes_if.slave bus
);

  localparam logic [LARGURA_CONT-1:0] CONT_MAX = {LARGURA_CONT{1'b1}};

  logic [N_BOTOES-1:0]     pulsos_w;
  logic [N_BOTOES-1:0]     estavel_w;
  logic [LARGURA_CONT-1:0] cont_q, cont_d;

  for (genvar k = 0; k < N_BOTOES; k++) begin : g_canal
    debounce_canal #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .ATIVO_BAIXO     (ATIVO_BAIXO)
`ifdef CONDICIONADOR_AUTOREPEAT_EN
      ,
      .REPEAT_ATRASO   (REPEAT_ATRASO),
      .REPEAT_PERIODO  (REPEAT_PERIODO)
`endif
    ) u_canal (
      .clk      (clk),
      .rst      (rst),
      .raw      (bus.botoes_raw[k]),
      .habilita (bus.habilita),
      .pulso    (pulsos_w[k]),
      .estavel  (estavel_w[k])
    );
  end

  // One move per cycle with any pulse; clear beats increment; saturate at all-ones
  always_comb begin
    cont_d = cont_q;
    if (bus.limpa_contagem) begin
      cont_d = '0;
    end else if ((|pulsos_w) && (cont_q != CONT_MAX)) begin
      cont_d = cont_q + 1'b1;
    end
  end

  // Move counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cont_q <= '0;
    end else begin
      cont_q <= cont_d;
    end
  end

  assign bus.pulsos           = pulsos_w;
  assign bus.estavel          = estavel_w;
  assign bus.contagem_jogadas = cont_q;
  assign bus.contagem_cheia   = (cont_q == CONT_MAX);

endmodule
